mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive data grants, while fetch is pending, after which fetch wins.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_req  input  1  instruction-fetch request, held until if_gnt.
REQ-006 SHALL have port if_addr  input  XLEN  fetch byte address; bits [1:0] ignored.
REQ-007 SHALL have port if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 SHALL have port if_rvalid  output  1  one-cycle pulse: if_rdata valid.
REQ-009 SHALL have port if_rdata  output  XLEN  fetched instruction word.
REQ-010 SHALL have port d_req  input  1  data request, held until d_gnt.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_funct3  input  3  access size/sign, typed funct3_mem_t.
REQ-013 SHALL have port d_addr  input  XLEN  data byte address.
REQ-014 SHALL have port d_wdata  input  XLEN  store data, right-aligned.
REQ-015 SHALL have port d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-016 SHALL have port d_rvalid  output  1  one-cycle pulse: data response (load data or store acknowledge).
REQ-017 SHALL have port d_rdata  output  XLEN  extended load result; 0 for stores and errors.
REQ-018 SHALL have port d_err  output  1  qualifies d_rvalid: misaligned or illegal access.
REQ-019 SHALL have port mem_req  output  1  memory request, held until mem_gnt.
REQ-020 SHALL have port mem_we  output  1  memory write enable.
REQ-021 SHALL have port mem_be  output  4  byte enables.
REQ-022 SHALL have port mem_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00}).
REQ-023 SHALL have port mem_wdata  output  XLEN  lane-replicated store data.
REQ-024 SHALL have port mem_gnt  input  1  memory accepted the request.
REQ-025 SHALL have port mem_rvalid  input  1  read data / write acknowledge; earliest the cycle after mem_gnt.
REQ-026 SHALL have port mem_rdata  input  XLEN  memory read word.

Function
REQ-027 SHALL implement the FSM IDLE -> ISSUE (drive mem_req with latched fields until mem_gnt) -> WAIT (until mem_rvalid) -> IDLE, with at most one transaction outstanding.
REQ-028 SHALL, in IDLE, combinationally select a winner, pulse its gnt in that same cycle, latch its request fields, and move to ISSUE; with no request it SHALL stay in IDLE.
REQ-029 SHALL give priority to data when both requests are pending, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-030 SHALL increment starve_cnt, saturating, on each data grant while if_req=1, and clear it on each fetch grant.
REQ-031 SHALL, on mem_rvalid in WAIT, register the response so that the owner's rvalid is high exactly the next cycle; the FSM re-enters IDLE in that cycle and may grant again in it.
REQ-032 SHALL give a minimum latency from gnt to rvalid of 3 cycles (mem_gnt in ISSUE, mem_rvalid the following cycle).
REQ-033 SHALL ignore mem_rvalid and mem_gnt outside WAIT and ISSUE respectively.
REQ-034 SHALL drive fetch and load requests with mem_we=0 and mem_be=4'b1111.
REQ-035 SHALL drive stores with: BYTE: mem_be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; HALF: mem_be=4'b0011<<(2*addr[1]), wdata={2{wdata[15:0]}}; WORD: mem_be=4'b1111.
REQ-036 SHALL extract load data by shifting mem_rdata right by 8*addr[1:0], then sign-extending for BYTE/HALF and zero-extending for BU/HU.
REQ-037 SHALL treat HALF/HU with addr[0]=1, WORD with addr[1:0]!=0, funct3 011/110/111, and stores with BU/HU as errors: pulse d_gnt, make no memory access, stay IDLE, and next cycle give d_rvalid=1, d_err=1, d_rdata=0.

Reset
REQ-038 SHALL, on rst_n low, immediately force IDLE and starve_cnt=0, drive every output to 0, and drop any in-flight transaction; a late mem_rvalid after reset SHALL be ignored.
REQ-039 SHALL leave IDLE no earlier than the first rising clk edge after rst_n deasserts.

Structure
REQ-040 SHALL add arb_state_t (IDLE/ISSUE/WAIT) and mem_owner_t (OWN_IF/OWN_D) to riscv_pkg and reuse funct3_mem_t from it.
REQ-041 SHALL place the combinational byte-enable, lane-replication and load-extend logic in one sub-module named mem_align.

Verification
REQ-042 SHALL cover a lone fetch at 0x104 with mem_rdata=0x00500093 -> mem_addr=0x104, mem_be=4'hF, if_rvalid 3 cycles after if_gnt with if_rdata=0x00500093.
REQ-043 SHALL cover an LB at 0x203 with mem_rdata=0x80FFFFFF -> d_rdata=0xFFFFFF80; an LBU at the same address -> d_rdata=0x00000080.
REQ-044 SHALL cover an SH at 0x12 with wdata=0xABCD1234 -> mem_we=1, mem_be=4'b1100, mem_wdata=0x12341234, mem_addr=0x10.
REQ-045 SHALL cover if_req and d_req held continuously -> 4 data grants, then 1 fetch grant, repeating.
REQ-046 SHALL cover an LW at 0x6 -> d_gnt, no mem_req, d_err=1 and d_rdata=0 next cycle; plus rst_n low during WAIT -> all outputs 0 immediately and no rvalid afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the memory arbiter.
//   funct3_mem_t : load/store size and sign encoding (RISC-V funct3 field)
//   arb_state_t  : arbiter FSM states
//   mem_owner_t  : which requester owns the in-flight memory transaction
package riscv_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_mem_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } mem_owner_t;

endpackage

// File: rtl/mem_align.sv
// mem_align: purely combinational data-side alignment helpers.
// Request side (driven by the live data request):
//   i_funct3, i_we, i_addr_lo, i_wdata -> o_be (byte enables),
//   o_wdata (lane-replicated store data), o_err (misaligned/illegal access)
// Response side (driven by the latched transaction fields):
//   i_ld_funct3, i_ld_addr_lo, i_rdata -> o_ld_data (shifted, extended load)
module mem_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  funct3_mem_t       i_funct3,
  input  logic              i_we,
  input  logic [1:0]        i_addr_lo,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [3:0]        o_be,
  output logic [XLEN-1:0]   o_wdata,
  output logic              o_err,
  input  funct3_mem_t       i_ld_funct3,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [XLEN-1:0] w_shifted;

  // Loads always read the full word; only stores narrow the byte enables.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_err   = 1'b0;
    case (i_funct3)
      F3_B: begin
        if (i_we) begin
          o_be    = 4'b0001 << i_addr_lo;
          o_wdata = {(XLEN/8){i_wdata[7:0]}};
        end
      end
      F3_H: begin
        o_err = i_addr_lo[0];
        if (i_we) begin
          o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_wdata = {(XLEN/16){i_wdata[15:0]}};
        end
      end
      F3_W:    o_err = |i_addr_lo;
      // Unsigned variants only make sense for loads.
      F3_BU:   o_err = i_we;
      F3_HU:   o_err = i_we | i_addr_lo[0];
      default: o_err = 1'b1;
    endcase
  end

  assign w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};

  always_comb begin
    o_ld_data = w_shifted;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_ld_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-outstanding memory port between an
// instruction-fetch requester and a data (load/store) requester.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr -> if_gnt        fetch request / accept pulse
//   if_rvalid, if_rdata             fetch response
//   d_req/d_we/d_funct3/d_addr/d_wdata -> d_gnt   data request / accept pulse
//   d_rvalid, d_rdata, d_err        data response (load data or store ack)
//   mem_req/we/be/addr/wdata        memory request, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata  memory handshake and read data
// Data wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  funct3_mem_t       d_funct3,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  arb_state_t        r_state, w_state_nxt;
  mem_owner_t        r_owner;
  logic [CNT_W-1:0]  r_starve_cnt;

  // Latched transaction fields.
  logic              r_we;
  logic [3:0]        r_be;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  funct3_mem_t       r_funct3;
  logic [1:0]        r_addr_lo;

  // Registered responses.
  logic              r_if_rvalid;
  logic [XLEN-1:0]   r_if_rdata;
  logic              r_d_rvalid;
  logic [XLEN-1:0]   r_d_rdata;
  logic              r_d_err;

  logic              w_if_gnt, w_d_gnt;
  logic              w_starved, w_pick_if;
  logic [3:0]        w_be;
  logic [XLEN-1:0]   w_wdata_rep;
  logic              w_d_err;
  logic [XLEN-1:0]   w_ld_data;

  mem_align #(.XLEN(XLEN)) u_mem_align (
    .i_funct3     (d_funct3),
    .i_we         (d_we),
    .i_addr_lo    (d_addr[1:0]),
    .i_wdata      (d_wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata_rep),
    .o_err        (w_d_err),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_pick_if = if_req && (!d_req || w_starved);

  // Grants are combinational; they are also qualified by rst_n so that they
  // read 0 while reset is asserted even though the state already reads IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_if_gnt    = 1'b0;
    w_d_gnt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          if (w_pick_if) begin
            w_if_gnt    = 1'b1;
            w_state_nxt = ISSUE;
          end else if (d_req) begin
            w_d_gnt = 1'b1;
            // Illegal accesses are answered locally without touching memory.
            if (!w_d_err) w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE:   if (mem_gnt)    w_state_nxt = WAIT;
      WAIT:    if (mem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && if_req && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= F3_B;
      r_addr_lo   <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;

      if (w_if_gnt) begin
        r_owner   <= OWN_IF;
        r_we      <= 1'b0;
        r_be      <= 4'b1111;
        r_addr    <= if_addr & WORD_MASK;
        r_wdata   <= '0;
        r_funct3  <= F3_W;
        r_addr_lo <= 2'b00;
      end else if (w_d_gnt && !w_d_err) begin
        r_owner   <= OWN_D;
        r_we      <= d_we;
        r_be      <= w_be;
        r_addr    <= d_addr & WORD_MASK;
        r_wdata   <= w_wdata_rep;
        r_funct3  <= d_funct3;
        r_addr_lo <= d_addr[1:0];
      end

      if (w_d_gnt && w_d_err) begin
        r_d_rvalid <= 1'b1;
        r_d_err    <= 1'b1;
        r_d_rdata  <= '0;
      end

      if (r_state == WAIT && mem_rvalid) begin
        if (r_owner == OWN_IF) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata;
        end else begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= r_we ? '0 : w_ld_data;
        end
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_err     = r_d_err;
  assign mem_req   = (r_state == ISSUE);
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
